// File: rtl/hex_entry_pkg.sv
// Shared FSM encoding and debounce counter sizing for the hex keypad entry block.
package hex_entry_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // The arming counter runs to DEBOUNCE_CYCLES+1, so size for one beyond that.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 2);
  endfunction

endpackage

// File: rtl/hex_entry_key_debounce.sv
// Synchronize, debounce and edge-detect one active-low key; press pulse lags a held key by DEBOUNCE_CYCLES+2 edges.
// Events stay disarmed after reset until the key is seen released, so a key held through reset never fires.
module key_debounce
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = '0;
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;

    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Two extra high cycles cover the synchronizer refilling with its reset value.
    if (!armed_q) begin
      if (sync2_q) begin
        if (arm_cnt_q == ARM_LAST) begin
          armed_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + CW'(1);
        end
      end else begin
        arm_cnt_d = '0;
      end
    end

    press_d = armed_q & stable_q & ~stable_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/hex_entry.sv
// Two-key hex byte entry: shift nibbles into staging, enter captures a byte held valid until ack_in.
// Registers update DEBOUNCE_CYCLES+3 edges after a clean key press; enters during HOLD are dropped.
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw_in,
  input  logic       key_shift_n,
  input  logic       key_enter_n,
  output logic [7:0] staging_out,
  output logic [1:0] digit_count_out,
  output logic [7:0] value_out,
  output logic       valid_out,
  input  logic       ack_in
);

  logic       shift_evt, enter_evt;
  logic [3:0] sw_sync1_q, sw_sync2_q;
  logic [7:0] staging_q, staging_d;
  logic [1:0] count_q, count_d;
  logic [7:0] value_q, value_d;
  logic       valid_q, valid_d;
  state_e     state_q, state_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shift (
    .clock (clock),
    .reset (reset),
    .key_n (key_shift_n),
    .press (shift_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clock (clock),
    .reset (reset),
    .key_n (key_enter_n),
    .press (enter_evt)
  );

  always_comb begin
    staging_d = staging_q;
    count_d   = count_q;
    value_d   = value_q;
    valid_d   = valid_q;
    state_d   = state_q;

    if (shift_evt) begin
      staging_d = {staging_q[3:0], sw_sync2_q};
      if (count_q != 2'd2) begin
        count_d = count_q + 2'd1;
      end
    end

    // Capture uses staging_d so a same-cycle shift lands in the byte.
    case (state_q)
      IDLE: begin
        if (enter_evt) begin
          value_d = staging_d;
          valid_d = 1'b1;
          count_d = 2'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ack_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      staging_q  <= '0;
      count_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      state_q    <= IDLE;
    end else begin
      sw_sync1_q <= sw_in;
      sw_sync2_q <= sw_sync1_q;
      staging_q  <= staging_d;
      count_q    <= count_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      state_q    <= state_d;
    end
  end

  assign staging_out     = staging_q;
  assign digit_count_out = count_q;
  assign value_out       = value_q;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry with a short debounce window.
module tb_hex_entry;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sw_in;
  logic       key_shift_n;
  logic       key_enter_n;
  logic [7:0] staging_out;
  logic [1:0] digit_count_out;
  logic [7:0] value_out;
  logic       valid_out;
  logic       ack_in;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  hex_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .sw_in           (sw_in),
    .key_shift_n     (key_shift_n),
    .key_enter_n     (key_enter_n),
    .staging_out     (staging_out),
    .digit_count_out (digit_count_out),
    .value_out       (value_out),
    .valid_out       (valid_out),
    .ack_in          (ack_in)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input bit sh, input bit en, input int hold);
    if (sh) key_shift_n = 1'b0;
    if (en) key_enter_n = 1'b0;
    step(hold);
    key_shift_n = 1'b1;
    key_enter_n = 1'b1;
    step(12);
  endtask

  initial begin
    reset = 1'b1;
    sw_in = 4'hA;
    key_shift_n = 1'b1;
    key_enter_n = 1'b1;
    ack_in = 1'b0;

    step(3);
    reset = 1'b0;
    check("rst_staging", staging_out, 8'h00);
    check("rst_count", digit_count_out, 2'd0);
    check("rst_value", value_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);

    // Key low from edge 10: update exactly on edge 17.
    while (cyc < 10) @(posedge clock);
    #1;
    key_shift_n = 1'b0;
    step(6);
    check("lat_early_staging", staging_out, 8'h00);
    check("lat_early_count", digit_count_out, 2'd0);
    step(1);
    check("lat_staging", staging_out, 8'h0A);
    check("lat_count", digit_count_out, 2'd1);
    key_shift_n = 1'b1;
    step(12);

    // Shift 3, shift 5, enter.
    sw_in = 4'h3;
    press(1, 0, 6);
    sw_in = 4'h5;
    press(1, 0, 6);
    check("sat_count", digit_count_out, 2'd2);
    press(0, 1, 6);
    check("cap_value", value_out, 8'h35);
    check("cap_valid", valid_out, 1'b1);
    check("cap_count", digit_count_out, 2'd0);

    // Enter in HOLD is discarded; shifting still works.
    press(0, 1, 6);
    sw_in = 4'h7;
    press(1, 0, 6);
    check("hold_value", value_out, 8'h35);
    check("hold_staging", staging_out, 8'h57);
    check("hold_valid", valid_out, 1'b1);

    ack_in = 1'b1;
    step(1);
    ack_in = 1'b0;
    check("ack_valid", valid_out, 1'b0);
    check("ack_value", value_out, 8'h35);

    ack_in = 1'b1;
    step(1);
    ack_in = 1'b0;
    step(2);
    check("idle_ack_valid", valid_out, 1'b0);

    // Capture 57, then land an enter event on the same edge as ack.
    press(0, 1, 6);
    check("cap2_value", value_out, 8'h57);
    check("cap2_valid", valid_out, 1'b1);
    key_enter_n = 1'b0;
    step(D + 2);
    ack_in = 1'b1;
    step(1);
    ack_in = 1'b0;
    check("ack_enter_valid", valid_out, 1'b0);
    step(4);
    key_enter_n = 1'b1;
    step(12);
    check("ack_enter_valid_late", valid_out, 1'b0);
    check("ack_enter_value", value_out, 8'h57);

    // Bounces shorter than the debounce window.
    for (int i = 0; i < 4; i++) begin
      key_shift_n = 1'b0;
      step(3);
      key_shift_n = 1'b1;
      step(2);
    end
    step(10);
    check("bounce_staging", staging_out, 8'h57);
    check("bounce_count", digit_count_out, 2'd0);

    // Same-cycle shift and enter from staging 01.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    sw_in = 4'h1;
    press(1, 0, 6);
    check("pre_staging", staging_out, 8'h01);
    sw_in = 4'h2;
    press(1, 1, 6);
    check("both_value", value_out, 8'h12);
    check("both_count", digit_count_out, 2'd0);
    check("both_staging", staging_out, 8'h12);
    check("both_valid", valid_out, 1'b1);

    // Reset in HOLD with enter held through it.
    key_enter_n = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_hold_staging", staging_out, 8'h00);
    check("rst_hold_count", digit_count_out, 2'd0);
    check("rst_hold_value", value_out, 8'h00);
    check("rst_hold_valid", valid_out, 1'b0);
    step(20);
    check("held_no_cap", valid_out, 1'b0);
    key_enter_n = 1'b1;
    step(15);
    check("release_no_cap", valid_out, 1'b0);
    sw_in = 4'hC;
    press(1, 0, 6);
    press(0, 1, 6);
    check("repress_value", value_out, 8'h0C);
    check("repress_valid", valid_out, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
